// File: rtl/instr_fetch_unit_if.sv
// Instruction-fetch bus bundle: the instruction-memory req/ack port and the
// decode-side exchange with the control unit. The fetch unit uses the master
// modport. The memory/control-unit side uses the slave modport.
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 60
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic [3:0]         opcode;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               branch_en;
    logic               jump_en;
    logic               branch_cond;
    logic               stall;

    modport master (
        output imem_req, imem_addr, opcode, instr, instr_valid,
        input  imem_ack, imem_rdata, branch_en, jump_en, branch_cond, stall
    );

    modport slave (
        input  imem_req, imem_addr, opcode, instr, instr_valid,
        output imem_ack, imem_rdata, branch_en, jump_en, branch_cond, stall
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch and sequencing unit for the 60-bit processor.
// The unit owns the PC and fetches over a req/ack handshake. It holds the
// fetched word in the instruction register and presents its opcode for decode.
// It then picks the next PC from the control unit's jump/branch response.
// Opcode 4'hF halts the unit until reset.
// Optional feature macro: IFU_TIMEOUT_EN. When it is defined, an ack timeout
// counter and the fetch_err output are added. After TIMEOUT ack-less FETCH
// cycles, fetch_err is set and the unit halts.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 60,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef IFU_TIMEOUT_EN
    ,
    parameter int                TIMEOUT  = 255
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
`ifdef IFU_TIMEOUT_EN
    ,
    output logic               fetch_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [3:0] OP_HALT = 4'hF;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  pc_reg, pc_next;
    logic [INSTR_W-1:0] ir_reg, ir_next;
    logic [ADDR_W-1:0]  target;

`ifdef IFU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             err_reg, err_next;
`endif

    // The branch/jump target is the low ADDR_W bits of the instruction.
    assign target = ir_reg[ADDR_W-1:0];

    // This block holds the state, PC and instruction register. All of them drop to their reset values asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            pc_reg    <= RESET_PC;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
        end
    end

`ifdef IFU_TIMEOUT_EN
    // This block holds the timeout counter and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            err_reg <= err_next;
        end
    end
`endif

    // This block selects the next state and computes the next PC and IR values.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
`ifdef IFU_TIMEOUT_EN
        cnt_next   = cnt_reg;
        err_next   = err_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                state_next = S_FETCH;
`ifdef IFU_TIMEOUT_EN
                cnt_next   = '0;
`endif
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    ir_next    = bus.imem_rdata;
                    state_next = S_DECODE;
                end
`ifdef IFU_TIMEOUT_EN
                else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = S_HALT;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
`endif
            end
            S_DECODE: begin
                if (!bus.stall) begin
                    if (ir_reg[INSTR_W-1 -: 4] == OP_HALT) begin
                        // The halt instruction leaves the PC pointing at itself.
                        state_next = S_HALT;
                    end else begin
                        state_next = S_FETCH;
`ifdef IFU_TIMEOUT_EN
                        cnt_next   = '0;
`endif
                        if (bus.jump_en)
                            pc_next = target;
                        else if (bus.branch_en && bus.branch_cond)
                            pc_next = target;
                        else
                            pc_next = pc_reg + ADDR_W'(1);
                    end
                end
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // The handshake and status outputs are decoded directly from the state register.
    assign bus.imem_req    = (state_reg == S_FETCH);
    assign bus.instr_valid = (state_reg == S_DECODE);
    assign bus.imem_addr   = pc_reg;
    assign bus.instr       = ir_reg;
    assign bus.opcode      = ir_reg[INSTR_W-1 -: 4];
    assign pc              = pc_reg;
    assign halted          = (state_reg == S_HALT);
`ifdef IFU_TIMEOUT_EN
    assign fetch_err       = err_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. The bench plays both instruction
// memory and control unit. The expected PC sequence comes from a plain
// arithmetic reference model of the sequencing rules.
module tb_instr_fetch_unit;
    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 60;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic              halted;
`ifdef IFU_TIMEOUT_EN
    logic              fetch_err;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] model_pc;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) ifc ();

    instr_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .RESET_PC(16'h0000)
`ifdef IFU_TIMEOUT_EN
        ,
        .TIMEOUT (8)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (ifc),
        .pc       (pc),
        .halted   (halted)
`ifdef IFU_TIMEOUT_EN
        ,
        .fetch_err(fetch_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: the next PC depends only on the jump/branch response and the target field.
    function automatic logic [15:0] model_next(input logic [15:0] cur, input logic [59:0] w,
                                               input bit j, input bit b, input bit c);
        int unsigned s;
        if (j || (b && c)) return w[15:0];
        s = (32'(cur) + 1) % 65536;
        return s[15:0];
    endfunction

    function automatic logic [59:0] mk_word(input logic [3:0] op, input logic [15:0] tgt);
        logic [63:0] r;
        r = {$urandom, $urandom};
        return {op, r[39:0], tgt};
    endfunction

    // One instruction: this task waits for the fetch, acks it after ack_delay cycles, answers the decode and checks the next PC.
    task automatic run_instr(input logic [59:0] word, input int ack_delay,
                             input bit j, input bit b, input bit c, input int stall_n);
        int waited;
        int valid_cnt;
        logic [3:0] op;
        op = word[59:56];
        waited = 0;
        while (ifc.imem_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("fetch_no_gap", waited, 0);
        for (int k = 0; k < ack_delay; k++) begin
            chk("wait_req", ifc.imem_req, 1'b1);
            chk("wait_addr", ifc.imem_addr, model_pc);
            ifc.imem_ack   = 1'b0;
            ifc.imem_rdata = mk_word(4'h0, 16'h0);
            @(negedge clk);
        end
        chk("fetch_req", ifc.imem_req, 1'b1);
        chk("fetch_addr", ifc.imem_addr, model_pc);
        ifc.imem_ack   = 1'b1;
        ifc.imem_rdata = word;
        @(negedge clk);
        ifc.imem_ack = 1'b0;
        chk("dec_req_low", ifc.imem_req, 1'b0);
        chk("dec_opcode", ifc.opcode, op);
        chk("dec_instr", ifc.instr, word);
        ifc.jump_en     = j;
        ifc.branch_en   = b;
        ifc.branch_cond = c;
        valid_cnt = 0;
        for (int k = 0; k <= stall_n; k++) begin
            if (ifc.instr_valid === 1'b1) valid_cnt++;
            ifc.stall      = (k < stall_n);
            ifc.imem_ack   = 1'($urandom_range(0, 1));
            ifc.imem_rdata = mk_word(4'($urandom_range(0, 15)), 16'($urandom));
            @(negedge clk);
            ifc.imem_ack = 1'b0;
            if (k < stall_n) begin
                chk("stall_pc", pc, model_pc);
                chk("stall_instr", ifc.instr, word);
                chk("stall_req", ifc.imem_req, 1'b0);
            end
        end
        chk("valid_cycles", valid_cnt, stall_n + 1);
        ifc.stall       = 1'b0;
        ifc.jump_en     = 1'b0;
        ifc.branch_en   = 1'b0;
        ifc.branch_cond = 1'b0;
        if (op == 4'hF) begin
            chk("halt_flag", halted, 1'b1);
            chk("halt_req", ifc.imem_req, 1'b0);
            chk("halt_pc", pc, model_pc);
        end else begin
            model_pc = model_next(model_pc, word, j, b, c);
            chk("next_req", ifc.imem_req, 1'b1);
            chk("next_addr", ifc.imem_addr, model_pc);
            chk("next_valid", ifc.instr_valid, 1'b0);
        end
        $display("instr op=%h ackdly=%0d j=%0d b=%0d c=%0d stall=%0d -> pc=%h", op, ack_delay, j, b, c,
                 stall_n, pc);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, ifc.imem_req, 1'b0);
        chk({tag, "_valid"}, ifc.instr_valid, 1'b0);
        chk({tag, "_halted"}, halted, 1'b0);
        chk({tag, "_pc"}, pc, 16'h0000);
        chk({tag, "_opcode"}, ifc.opcode, 4'h0);
        chk({tag, "_instr"}, ifc.instr, 60'h0);
`ifdef IFU_TIMEOUT_EN
        chk({tag, "_ferr"}, fetch_err, 1'b0);
`endif
    endtask

    initial begin
        int t0;
        int req_cnt;
        logic [59:0] w;

        ifc.imem_ack    = 1'b0;
        ifc.imem_rdata  = '0;
        ifc.branch_en   = 1'b0;
        ifc.jump_en     = 1'b0;
        ifc.branch_cond = 1'b0;
        ifc.stall       = 1'b0;
        rst_n           = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n    = 1'b1;
        model_pc = 16'h0000;
        @(negedge clk);
        chk("first_req_after_release", ifc.imem_req, 1'b1);

        // Step 1: sequential fetch of four opcode-0 instructions, two cycles each.
        for (int k = 0; k < 4; k++) begin
            chk("seq_addr", ifc.imem_addr, 16'(k));
            t0 = cyc;
            run_instr(mk_word(4'h0, 16'($urandom)), 0, 0, 0, 0, 0);
            chk("seq_cycles", cyc - t0, 2);
        end

        // Step 2: a jump at PC 5, then a not-taken branch at PC 5, then a taken branch, then jump and branch together.
        run_instr(mk_word(4'h0, 16'h1111), 0, 0, 0, 0, 0);
        chk("at_pc5", ifc.imem_addr, 16'h0005);
        run_instr(mk_word(4'h3, 16'h0040), 0, 1, 0, 0, 0);
        chk("jump_target", ifc.imem_addr, 16'h0040);
        run_instr(mk_word(4'h3, 16'h0005), 0, 1, 0, 0, 0);
        run_instr(mk_word(4'h5, 16'h0040), 0, 0, 1, 0, 0);
        chk("branch_not_taken", ifc.imem_addr, 16'h0006);
        run_instr(mk_word(4'h5, 16'h0123), 1, 0, 1, 1, 0);
        chk("branch_taken", ifc.imem_addr, 16'h0123);
        run_instr(mk_word(4'h6, 16'h0200), 0, 1, 1, 0, 0);
        chk("jump_and_branch", ifc.imem_addr, 16'h0200);

        // Step 3: a 3-cycle stall in DECODE. Step 4: ack delayed 4 cycles.
        run_instr(mk_word(4'h2, 16'h7777), 0, 0, 0, 0, 3);
        chk("after_stall", ifc.imem_addr, 16'h0201);
        run_instr(mk_word(4'h2, 16'h7777), 4, 0, 0, 0, 0);

        // Step 5: jump to 0xFFFF, then a sequential instruction wraps the PC to 0x0000.
        run_instr(mk_word(4'h1, 16'hFFFF), 0, 1, 0, 0, 0);
        run_instr(mk_word(4'h0, 16'h1234), 0, 0, 0, 0, 0);
        chk("pc_wrap", ifc.imem_addr, 16'h0000);

        // Step 6: 40 instructions with random control responses, ack delays and stalls.
        for (int k = 0; k < 40; k++) begin
            w = mk_word(4'($urandom_range(0, 14)), 16'($urandom));
            run_instr(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        // Step 7: opcode F halts the unit. No further fetches occur, even when ack pulses arrive.
        run_instr(mk_word(4'hF, 16'h0040), 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            ifc.imem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("halt_hold_req", ifc.imem_req, 1'b0);
            chk("halt_hold_flag", halted, 1'b1);
            chk("halt_hold_pc", pc, model_pc);
        end
        ifc.imem_ack = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("halt_reset");
        @(negedge clk);
        rst_n    = 1'b1;
        model_pc = 16'h0000;
        @(negedge clk);

        // Step 8: an asynchronous reset during a fetch.
        run_instr(mk_word(4'h4, 16'h1234), 0, 1, 0, 0, 0);
        chk("pre_reset_addr", ifc.imem_addr, 16'h1234);
        @(negedge clk);
        chk("midfetch_req", ifc.imem_req, 1'b1);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("midfetch_reset");
        @(negedge clk);
        rst_n    = 1'b1;
        model_pc = 16'h0000;
        @(negedge clk);

        // Step 9: an asynchronous reset during a decode.
        run_instr(mk_word(4'h4, 16'h0777), 0, 1, 0, 0, 0);
        w = mk_word(4'h9, 16'h0abc);
        ifc.imem_ack   = 1'b1;
        ifc.imem_rdata = w;
        @(negedge clk);
        ifc.imem_ack = 1'b0;
        chk("middec_valid", ifc.instr_valid, 1'b1);
        chk("middec_instr", ifc.instr, w);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("middecode_reset");
        @(negedge clk);
        rst_n    = 1'b1;
        model_pc = 16'h0000;
        @(negedge clk);

`ifdef IFU_TIMEOUT_EN
        // Step 10: the ack never arrives, so fetch_err and halted are set after 8 FETCH cycles.
        req_cnt = 0;
        for (int k = 0; k < 30 && ifc.imem_req === 1'b1; k++) begin
            chk("to_addr", ifc.imem_addr, 16'h0000);
            req_cnt++;
            @(negedge clk);
        end
        chk("to_fetch_cycles", req_cnt, 8);
        chk("to_fetch_err", fetch_err, 1'b1);
        chk("to_halted", halted, 1'b1);
        repeat (4) @(negedge clk);
        chk("to_err_sticky", fetch_err, 1'b1);
        chk("to_no_req", ifc.imem_req, 1'b0);
        $display("timeout fetch_cycles=%0d fetch_err=%0d halted=%0d", req_cnt, fetch_err, halted);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("timeout_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`else
        req_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (ifc.imem_req === 1'b1) req_cnt++;
            @(negedge clk);
        end
        chk("no_timeout_wait", req_cnt, 12);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch and sequencing unit for the 60-bit processor: the producer of the 4-bit `opcode` that the control unit decodes, and the consumer of the control unit's `branch_en`/`jump_en` responses. It owns the program counter and runs a req/ack handshake with instruction memory. It holds each fetched 60-bit instruction in an instruction register and presents its opcode for decode. It then computes the next PC from the control unit's response.

## Interface
- `ADDR_W`, 16, PC / instruction-memory address width; also width of the target field.
- `INSTR_W`, 60, instruction width.
- `RESET_PC`, 0, PC value loaded on reset.
- `TIMEOUT`, 255, max wait cycles for `imem_ack` (used only with `IFU_TIMEOUT_EN`).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request; high exactly while in FETCH.
- `imem_addr`  out  ADDR_W  equals `pc`.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  INSTR_W  fetched instruction.
- `opcode`  out  4  `ir[59:56]`, to the control unit.
- `instr`  out  INSTR_W  full instruction register.
- `instr_valid`  out  1  high while in DECODE.
- `branch_en`  in  1  from control unit; instruction is a conditional branch.
- `jump_en`  in  1  from control unit; instruction is an unconditional jump.
- `branch_cond`  in  1  branch condition from the ALU.
- `stall`  in  1  hold the current instruction in DECODE.
- `pc`  out  ADDR_W  current program counter.
- `halted`  out  1  high in HALT.
- `fetch_err`  out  1  fetch timeout flag; present only with `IFU_TIMEOUT_EN`.

## Operation
- States: IDLE, FETCH, DECODE, HALT. Reset state is IDLE.
- IDLE → FETCH unconditionally on the next edge.
- FETCH:
  - `imem_req`=1 with `imem_addr`=`pc`, held stable until `imem_ack` is sampled high.
  - On ack: `ir` ← `imem_rdata`, go to DECODE.
- DECODE:
  - `instr_valid`=1.
  - The control unit decodes `opcode` combinationally and returns `branch_en`, `jump_en` and `branch_cond` in the same cycle.
  - If `stall`=1: stay in DECODE; `pc` and `ir` unchanged.
  - Otherwise, next PC, in priority order:
    - `jump_en` → target.
    - `branch_en & branch_cond` → target.
    - Otherwise → `pc+1`.
  - target = `ir[ADDR_W-1:0]`.
  - Return to FETCH.
- Opcode 4'hF is HALT. When sampled in DECODE with `stall`=0, go to HALT; `pc` is not updated.
- HALT is left only by reset.
- Arithmetic: `pc+1` wraps modulo 2^ADDR_W (0xFFFF → 0x0000 at the default width). There is no overflow flag.
- `imem_ack` is ignored in every state except FETCH.
- `jump_en` and `branch_en` both high: jump wins. Result is the same target.

## Timing
- Reset values:
  - `pc`=RESET_PC, `ir`=0 (so `opcode`=0).
  - `imem_req`=0, `instr_valid`=0, `halted`=0, `fetch_err`=0.
- `imem_req`, `instr_valid` and `halted` are decoded from the state register, so they change only on clock edges or on reset.
- Minimum 2 cycles per instruction: 1 FETCH cycle when ack is high in the first request cycle, plus 1 DECODE cycle.
- First `imem_req` rises one cycle after `rst_n` deasserts, because IDLE lasts one cycle.
- New `pc` is visible on `imem_addr` in the FETCH cycle immediately following DECODE.
- Reset asserted mid-fetch or mid-decode: all outputs drop to their reset values immediately (asynchronously). Any in-flight fetch is abandoned; memory must tolerate a dropped request.

## Configuration
- `IFU_TIMEOUT_EN` defined:
  - A counter of consecutive FETCH cycles with `imem_ack`=0 is added. It clears on entering FETCH.
  - When the count reaches `TIMEOUT` with no ack, `fetch_err` is set, the unit goes to HALT and `halted`=1.
  - `fetch_err` stays set until reset.
- `IFU_TIMEOUT_EN` undefined: no counter and no `fetch_err` port. FETCH waits indefinitely.

## Test plan
- Reset release, memory acks every request in its first cycle, instructions opcode 0 → `imem_addr` sequence 0,1,2,3 at 2 cycles per address; `instr_valid` pulses once per instruction.
- Instruction at PC 5 with `jump_en`=1 and target field 0x0040 → next `imem_addr`=0x0040; with `branch_en`=1 and `branch_cond`=0 → next `imem_addr`=6.
- `stall` held high for 3 cycles in DECODE → `instr_valid` high for 4 cycles, `pc` unchanged, exactly one subsequent `imem_req`.
- Ack delayed 4 cycles → `imem_addr` stable and `imem_req` high for 5 cycles. Ack pulses injected during DECODE are ignored.
- PC 0xFFFF, sequential instruction → next `imem_addr`=0x0000. Opcode 4'hF → `halted`=1 and no further `imem_req` until `rst_n` is pulsed low.
- With `IFU_TIMEOUT_EN` and `TIMEOUT`=8, ack never asserted → `fetch_err`=1 and `halted`=1 after 8 FETCH cycles. Asserting `rst_n`=0 mid-fetch clears all outputs in the same cycle.
